matmul_stream_ctrl: RTL

- Stream wrapper around the Tn x Tn matrix-multiply engine.
- Accepts operand words on a valid/ready input stream and writes them into the X and Y operand memories, row-major.
- Pulses the engine's start, waits for its done pulse, then reads the Z result memory and emits it on a valid/ready output stream with last-word marking.
- Sits directly upstream (operand load) and downstream (result drain) of the engine.

---
 rtl/matmul_stream_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl
//   Stream wrapper around a Tn x Tn matrix-multiply engine. Operand words
//   arrive on a valid/ready stream (all X words, then all Y words, row-major)
//   and are written into the engine's X and Y operand memories. The engine is
//   then kicked with a one-cycle start pulse. After its done pulse, the Z
//   result memory is read out word by word onto a valid/ready output stream,
//   with the final word of the frame flagged by out_last.
//
// Ports
//   clock, reset             : clock; asynchronous active-high reset
//   in_data/valid/ready      : operand input stream
//   x_wr_en/addr, x_din      : X operand memory write port
//   y_wr_en/addr, y_din      : Y operand memory write port
//   mm_start / mm_done       : engine handshake pulses
//   z_rd_addr / z_dout       : Z result memory read port (1-cycle read latency)
//   out_data/valid/ready/last: result output stream
//   busy                     : low only while idle in LOAD with nothing loaded
module matmul_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int Tn         = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  x_wr_en,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic                  y_wr_en,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int N  = Tn * Tn;

  localparam logic [CW-1:0]         N_CNT     = CW'(N);
  localparam logic [CW-1:0]         LAST_LOAD = CW'(2 * N - 1);
  localparam logic [CW-1:0]         LAST_OUT  = CW'(N - 1);
  // Y address is cnt-N; computing it modulo 2^ADDR_WIDTH is exact because
  // the true result is always below N <= 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] N_ADDR    = ADDR_WIDTH'(N);

  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_KICK = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Keeps in_ready low while reset is held and rises one cycle after release.
  logic          armed_q;

  logic xfer;
  logic in_x;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  assign in_ready = (state_q == S_LOAD) && armed_q;
  assign xfer     = in_valid && in_ready;
  assign in_x     = (cnt_q < N_CNT);

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == LAST_LOAD) begin
            cnt_d   = '0;
            state_d = S_KICK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (mm_done) state_d = S_RD;
      S_RD:   state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST_OUT) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode. Memory write ports are forced to zero unless a write is
  // actually taking place so nothing leaks outside LOAD.
  always_comb begin
    x_wr_en   = 1'b0;
    x_wr_addr = '0;
    x_din     = '0;
    y_wr_en   = 1'b0;
    y_wr_addr = '0;
    y_din     = '0;
    z_rd_addr = '0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (xfer) begin
      if (in_x) begin
        x_wr_en   = 1'b1;
        x_wr_addr = cnt_q[ADDR_WIDTH-1:0];
        x_din     = in_data;
      end else begin
        y_wr_en   = 1'b1;
        y_wr_addr = cnt_q[ADDR_WIDTH-1:0] - N_ADDR;
        y_din     = in_data;
      end
    end
    // The read address comes only from the registered counter, so it stays
    // put through an output stall and z_dout keeps presenting the same word.
    if (state_q == S_RD || state_q == S_OUT) begin
      z_rd_addr = cnt_q[ADDR_WIDTH-1:0];
    end
    if (state_q == S_OUT) begin
      out_valid = 1'b1;
      out_data  = z_dout;
      out_last  = (cnt_q == LAST_OUT);
    end
  end

  assign mm_start = (state_q == S_KICK);
  assign busy     = !((state_q == S_LOAD) && (cnt_q == '0));

endmodule
